// File: rtl/host_tx_pkg.sv
// Shared definitions for the host TX descriptor path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package host_tx_pkg;

    localparam int DESC_W     = 13;
    localparam int MAX_CREDIT = 4;
    localparam int CREDIT_W   = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TS_GRANT = 3'd1,
        NTS_RD   = 3'd2,
        NTS_WAIT = 3'd3,
        NTS_OUT  = 3'd4
    } sched_state_t;

endpackage : host_tx_pkg

// File: rtl/host_credit_counter.sv
// Saturating credit counter: decrement on grant, increment on release.
// Latency: count updates on the clock edge that samples inc/dec.
// Backpressure: release at MAX_CREDIT is dropped; simultaneous inc+dec holds.
module host_credit_counter #(
    parameter int MAX_CREDIT = 4,
    parameter int CREDIT_W   = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_inc,
    input  logic                i_dec,
    output logic [CREDIT_W-1:0] ov_credit
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    // Credit register; a matched inc/dec pair cancels, each direction saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_credit <= CREDIT_MAX;
        end else if (i_inc && !i_dec) begin
            if (ov_credit != CREDIT_MAX) begin
                ov_credit <= ov_credit + CREDIT_ONE;
            end
        end else if (i_dec && !i_inc) begin
            if (ov_credit != '0) begin
                ov_credit <= ov_credit - CREDIT_ONE;
            end
        end
    end

endmodule : host_credit_counter

// File: rtl/host_descriptor_scheduler.sv
// Strict-priority TS > NTS descriptor scheduler onto the host TX descriptor interface.
// Latency: TS valid->wr/ack 1 cycle; NTS grant->rd 1, grant->wr 3 cycles. All outputs registered.
// Backpressure: grants need credit>0 and i_host_tx_rdy; NTS also needs gate open; optional
//               starvation guard under macro HOST_SCHED_STARVE_GUARD_EN.
module host_descriptor_scheduler #(
    parameter int DESC_W       = host_tx_pkg::DESC_W,
    parameter int MAX_CREDIT   = host_tx_pkg::MAX_CREDIT,
`ifdef HOST_SCHED_STARVE_GUARD_EN
    parameter int STARVE_LIMIT = 8,
`endif
    parameter int CREDIT_W     = host_tx_pkg::CREDIT_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DESC_W-1:0]   iv_ts_descriptor,
    input  logic                i_ts_descriptor_valid,
    output logic                o_ts_descriptor_ack,
    input  logic [DESC_W-1:0]   iv_nts_descriptor_rdata,
    input  logic                i_nts_fifo_empty,
    output logic                o_nts_descriptor_rd,
    input  logic                i_nts_gate_open,
    input  logic                i_host_tx_rdy,
    input  logic                i_descriptor_release,
    output logic [DESC_W-1:0]   ov_descriptor,
    output logic                o_descriptor_wr,
    output logic                o_descriptor_is_ts,
    output logic [CREDIT_W-1:0] ov_credit,
    output logic [15:0]         ov_debug_ts_cnt,
    output logic [15:0]         ov_debug_nts_cnt
);

    import host_tx_pkg::*;

    sched_state_t state;
    sched_state_t state_nxt;
    logic         grant_ts;
    logic         grant_nts;
    logic         eligible;
    logic         nts_elig;
    logic         force_nts;

    assign eligible = (ov_credit != '0) && i_host_tx_rdy;
    assign nts_elig = !i_nts_fifo_empty && i_nts_gate_open;

`ifdef HOST_SCHED_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;

    assign force_nts = nts_elig && (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Count back-to-back TS grants taken while NTS was waiting; any NTS grant or idle NTS clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!nts_elig || grant_nts) begin
            starve_cnt <= '0;
        end else if (grant_ts && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    assign force_nts = 1'b0;
`endif

    // Next-state: arbitrate only in IDLE; an NTS sequence runs to completion once started.
    always_comb begin
        state_nxt = state;
        grant_ts  = 1'b0;
        grant_nts = 1'b0;
        case (state)
            IDLE: begin
                if (eligible) begin
                    if (i_ts_descriptor_valid && !force_nts) begin
                        state_nxt = TS_GRANT;
                        grant_ts  = 1'b1;
                    end else if (nts_elig) begin
                        state_nxt = NTS_RD;
                        grant_nts = 1'b1;
                    end
                end
            end
            TS_GRANT: state_nxt = IDLE;
            NTS_RD:   state_nxt = NTS_WAIT;
            NTS_WAIT: state_nxt = NTS_OUT;
            NTS_OUT:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, decoded from the transition so strobes line up with the target state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ts_descriptor_ack <= 1'b0;
            o_nts_descriptor_rd <= 1'b0;
            o_descriptor_wr     <= 1'b0;
            o_descriptor_is_ts  <= 1'b0;
            ov_descriptor       <= '0;
            ov_debug_ts_cnt     <= '0;
            ov_debug_nts_cnt    <= '0;
        end else begin
            o_ts_descriptor_ack <= grant_ts;
            o_nts_descriptor_rd <= grant_nts;
            o_descriptor_wr     <= grant_ts || (state == NTS_WAIT);
            if (grant_ts) begin
                ov_descriptor      <= iv_ts_descriptor;
                o_descriptor_is_ts <= 1'b1;
                ov_debug_ts_cnt    <= ov_debug_ts_cnt + 16'd1;
            end else if (state == NTS_WAIT) begin
                // FIFO q is valid the cycle after the read pulse.
                ov_descriptor      <= iv_nts_descriptor_rdata;
                o_descriptor_is_ts <= 1'b0;
                ov_debug_nts_cnt   <= ov_debug_nts_cnt + 16'd1;
            end
        end
    end

    host_credit_counter #(
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W)
    ) u_credit (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_inc     (i_descriptor_release),
        .i_dec     (grant_ts || grant_nts),
        .ov_credit (ov_credit)
    );

endmodule : host_descriptor_scheduler

// File: doc/host_descriptor_scheduler.md
Name: host_descriptor_scheduler

Overview:
- Schedules host-transmit descriptors (13-bit bufids) from two sources onto one host TX descriptor interface.
- Source 1: TS descriptors presented by the time-slot logic with a valid/ack handshake.
- Source 2: NTS descriptors held in the host NTS queue FIFO. This block drives the FIFO read side.
- Arbitration is strict priority TS > NTS. NTS is also gated by the TAS gate signal and by downstream credit.

Parameters:
- DESC_W, 13: descriptor (bufid) width.
- MAX_CREDIT, 4: maximum descriptors outstanding at the host TX engine.
- CREDIT_W, 3: credit counter width; must hold MAX_CREDIT.
- STARVE_LIMIT, 8: consecutive TS grants allowed while NTS is pending (optional feature only).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- iv_ts_descriptor  in  DESC_W  TS descriptor
- i_ts_descriptor_valid  in  1  TS descriptor pending (level)
- o_ts_descriptor_ack  out  1  one-cycle pulse: TS descriptor consumed
- iv_nts_descriptor_rdata  in  DESC_W  NTS FIFO q (normal mode: valid the cycle after rd)
- i_nts_fifo_empty  in  1  NTS FIFO empty
- o_nts_descriptor_rd  out  1  one-cycle FIFO read pulse
- i_nts_gate_open  in  1  TAS gate state for the NTS queue
- i_host_tx_rdy  in  1  downstream can accept a descriptor
- i_descriptor_release  in  1  pulse: one outstanding descriptor finished (credit return)
- ov_descriptor  out  DESC_W  scheduled descriptor
- o_descriptor_wr  out  1  one-cycle write strobe for ov_descriptor
- o_descriptor_is_ts  out  1  qualifies ov_descriptor: 1 = TS, 0 = NTS
- ov_credit  out  CREDIT_W  current credit
- ov_debug_ts_cnt  out  16  TS descriptors issued, wraps
- ov_debug_nts_cnt  out  16  NTS descriptors issued, wraps

Behaviour:
- All outputs are registered.
- Reset values:
  - credit = MAX_CREDIT
  - state = IDLE
  - all strobes, ov_descriptor, o_descriptor_is_ts and debug counters = 0
- FSM states: IDLE, TS_GRANT, NTS_RD, NTS_WAIT, NTS_OUT.
- IDLE, grant eligibility: credit>0 and i_host_tx_rdy=1.
  - TS priority: if eligible and i_ts_descriptor_valid -> TS_GRANT; latch iv_ts_descriptor; credit-1.
  - Otherwise, if eligible, !i_nts_fifo_empty and i_nts_gate_open -> NTS_RD; credit-1.
  - Otherwise stay in IDLE.
- TS_GRANT (1 cycle):
  - o_descriptor_wr=1, o_descriptor_is_ts=1, o_ts_descriptor_ack=1; -> IDLE.
  - TS latency: valid sampled at edge N, wr/ack high during cycle N+1.
  - The TS source must drop or update valid in the ack cycle. IDLE re-samples it in the cycle after the ack.
- NTS_RD: o_nts_descriptor_rd=1 for exactly one cycle -> NTS_WAIT.
- NTS_WAIT: capture iv_nts_descriptor_rdata -> NTS_OUT.
- NTS_OUT: o_descriptor_wr=1, o_descriptor_is_ts=0 -> IDLE.
  - NTS latency: decision to wr = 3 cycles.
- Commitment:
  - Once an NTS grant leaves IDLE, it completes even if i_nts_gate_open, i_host_tx_rdy or valid change.
  - A TS valid arriving during the NTS sequence waits for IDLE.
- Only one FIFO read is ever in flight; no read is issued when empty is sampled high.
- Credit:
  - Decrement at grant; increment on i_descriptor_release.
  - Grant and release in the same cycle -> credit unchanged.
  - Release at credit==MAX_CREDIT is ignored (saturate).
  - credit==0 blocks both sources.
- Debug counters increment on each o_descriptor_wr, split by type, 16-bit wrap.
- Reset mid-sequence:
  - Asynchronous return to IDLE with credits restored.
  - An NTS descriptor popped but not yet emitted is discarded; the FIFO shares the same reset.

Optional Feature:
- Macro: HOST_SCHED_STARVE_GUARD_EN.
- Defined:
  - Counter starve_cnt counts consecutive TS grants made while NTS is eligible (non-empty, gate open).
  - When starve_cnt==STARVE_LIMIT and NTS is eligible, the next IDLE grant goes to NTS; starve_cnt then clears.
  - starve_cnt also clears on any NTS grant, and whenever NTS is not eligible.
- Undefined: pure strict priority; no counter logic is synthesized.

Decomposition:
- Shared package host_tx_pkg:
  - DESC_W
  - FSM state encoding constants (IDLE=0, TS_GRANT=1, NTS_RD=2, NTS_WAIT=3, NTS_OUT=4)
  - MAX_CREDIT default
- One sub-module: host_credit_counter (saturating up/down counter with simultaneous inc/dec). The FSM stays in the top module.

Test Plan:
- Reset, then idle: credit=4, all strobes 0; FIFO non-empty, gate open, rdy=1 -> rd pulse at cycle 1, wr at cycle 3 with FIFO q=13'h0A5, is_ts=0, nts_cnt=1.
- TS valid and NTS pending in the same cycle, iv_ts=13'h123 -> TS wins: wr+ack next cycle with 13'h123, is_ts=1; the NTS sequence follows afterwards.
- Five grants with no release -> credit reaches 0 after 4 grants and the fifth stalls. One release pulse -> the fifth is issued. Release coincident with a grant leaves credit unchanged.
- Gate closes one cycle after an NTS grant -> the sequence still completes. Gate closed in IDLE with FIFO non-empty -> no rd pulse.
- Reset asserted during NTS_WAIT -> outputs 0 immediately, credit=4, state IDLE, no wr emitted.
- With HOST_SCHED_STARVE_GUARD_EN, STARVE_LIMIT=8: TS valid held continuously with NTS pending -> the 9th grant is NTS, then TS resumes.
